// File: rtl/flash_audio_sequencer_if.sv
// rtl/flash_audio_sequencer_if.sv - flash read bus between the sequencer (master) and flash (slave)
interface flash_audio_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic [31:0]       flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/flash_audio_sequencer.sv
// rtl/flash_audio_sequencer.sv - fetches 32-bit song words from flash per sample tick, emits two 16-bit samples each
module flash_audio_sequencer #(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h07FFFF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic                    increment,
  input  logic                    pause,
  input  logic                    restart,
  flash_audio_sequencer_if.master flash,
  output logic [15:0]             sample,
  output logic                    sample_valid,
  output logic                    overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_FIRST,
    S_SECOND_WAIT,
    S_ADVANCE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              restart_pending_q, restart_pending_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] restart_addr;
  logic              play_tick;

  assign restart_addr = increment ? START_ADDR : END_ADDR;
  // restart outranks a simultaneous tick, so such a tick neither plays nor overruns
  assign play_tick    = sample_tick & ~pause & ~restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      addr_q            <= START_ADDR;
      dir_q             <= 1'b1;
      restart_pending_q <= 1'b0;
      data_q            <= '0;
      sample_q          <= '0;
      sample_valid_q    <= 1'b0;
      overrun_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      dir_q             <= dir_d;
      restart_pending_q <= restart_pending_d;
      data_q            <= data_d;
      sample_q          <= sample_d;
      sample_valid_q    <= sample_valid_d;
      overrun_q         <= overrun_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    dir_d             = dir_q;
    restart_pending_d = restart_pending_q | restart;
    data_d            = data_q;
    sample_d          = sample_q;
    sample_valid_d    = 1'b0;
    overrun_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (restart_pending_q) begin
          addr_d            = restart_addr;
          dir_d             = increment;
          restart_pending_d = 1'b0;
        end else if (play_tick) begin
          dir_d   = increment;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        overrun_d = sample_tick & ~restart;
        if (!flash.flash_waitrequest) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        overrun_d = sample_tick & ~restart;
        if (flash.flash_readdatavalid) begin
          // An accepted read is allowed to finish; a pending restart discards its data.
          if (restart_pending_q || restart) begin
            addr_d            = restart_addr;
            dir_d             = increment;
            restart_pending_d = 1'b0;
            state_d           = S_IDLE;
          end else begin
            data_d         = flash.flash_readdata;
            sample_d       = dir_q ? flash.flash_readdata[15:0] : flash.flash_readdata[31:16];
            sample_valid_d = 1'b1;
            state_d        = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        overrun_d = sample_tick & ~restart;
        state_d   = S_SECOND_WAIT;
      end
      S_SECOND_WAIT: begin
        if (restart_pending_q) begin
          addr_d            = restart_addr;
          dir_d             = increment;
          restart_pending_d = 1'b0;
          state_d           = S_IDLE;
        end else if (play_tick) begin
          sample_d       = dir_q ? data_q[31:16] : data_q[15:0];
          sample_valid_d = 1'b1;
          state_d        = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (restart_pending_q) begin
          addr_d            = restart_addr;
          dir_d             = increment;
          restart_pending_d = 1'b0;
        end else if (dir_q) begin
          addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + 1'b1;
        end else begin
          addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flash.flash_read    = (state_q == S_REQ);
  assign flash.flash_address = addr_q;
  assign sample              = sample_q;
  assign sample_valid        = sample_valid_q;
  assign overrun             = overrun_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb/tb_flash_audio_sequencer.sv - directed bench with flash responder model and sample/address scoreboards
module tb_flash_audio_sequencer;
  localparam int            AW = 23;
  localparam logic [AW-1:0] SA = '0;
  localparam logic [AW-1:0] EA = 23'd7;

  logic        clk = 1'b0;
  logic        reset, sample_tick, increment, pause, restart;
  logic [15:0] sample;
  logic        sample_valid, overrun;

  flash_audio_sequencer_if #(.ADDR_W(AW)) bus ();

  flash_audio_sequencer #(.ADDR_W(AW), .START_ADDR(SA), .END_ADDR(EA)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .increment    (increment),
    .pause        (pause),
    .restart      (restart),
    .flash        (bus.master),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    bit          first;
  } samp_t;

  samp_t         sq[$];
  logic [AW-1:0] aq[$];
  int checks = 0, failures = 0, cyc = 0;
  int cfg_wait = 2, cfg_lat = 2, wait_left = 0, resp_cnt = 0, rdv_cyc = 0;
  int accept_cnt = 0, sv_cnt = 0, ov_cnt = 0;
  bit in_req = 1'b0;
  logic [31:0] resp_data = '0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == SA) return 32'hBBBB_AAAA;
    if (a == EA) return 32'h2222_1111;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flash responder: waitrequest for cfg_wait cycles, then readdatavalid cfg_lat cycles after acceptance.
  always @(negedge clk) begin
    bus.flash_readdatavalid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.flash_readdatavalid = 1'b1;
        bus.flash_readdata      = resp_data;
        rdv_cyc                 = cyc;
      end
    end
    if (reset || !bus.flash_read) begin
      bus.flash_waitrequest = 1'b0;
      in_req                = 1'b0;
    end else begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_left = cfg_wait;
      end
      if (wait_left > 0) begin
        bus.flash_waitrequest = 1'b1;
        wait_left--;
      end else begin
        bus.flash_waitrequest = 1'b0;
        in_req                = 1'b0;
        accept_cnt++;
        check("read_expected", 32'(aq.size() > 0), 32'd1);
        if (aq.size() > 0) check("flash_address", 32'(bus.flash_address), 32'(aq.pop_front()));
        resp_data = mem_word(bus.flash_address);
        resp_cnt  = cfg_lat;
      end
    end
  end

  always @(negedge clk) begin
    samp_t e;
    if (!reset && sample_valid) begin
      sv_cnt++;
      check("sample_expected", 32'(sq.size() > 0), 32'd1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        check("sample", 32'(sample), 32'(e.val));
        if (e.first) check("first_latency", 32'(cyc - rdv_cyc), 32'd1);
      end
    end
    if (!reset && overrun) ov_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    cycles(3);
  endtask

  task automatic expect_word(input logic [AW-1:0] a, input bit fwd);
    logic [31:0] w;
    w = mem_word(a);
    aq.push_back(a);
    sq.push_back('{fwd ? w[15:0] : w[31:16], 1'b1});
    sq.push_back('{fwd ? w[31:16] : w[15:0], 1'b0});
  endtask

  task automatic play_word(input logic [AW-1:0] a, input bit fwd);
    expect_word(a, fwd);
    tick();
    cycles(20);
    tick();
    cycles(20);
  endtask

  initial begin
    int base, ov_base, sv_base;
    bus.flash_waitrequest   = 1'b0;
    bus.flash_readdata      = '0;
    bus.flash_readdatavalid = 1'b0;
    reset = 1'b1; sample_tick = 1'b0; increment = 1'b1; pause = 1'b0; restart = 1'b0;
    cycles(3);
    check("rst_flash_read", 32'(bus.flash_read), 32'd0);
    check("rst_address", 32'(bus.flash_address), 32'(SA));
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    cycles(2);

    // forward play from START
    play_word(SA, 1'b1);
    play_word(SA + 1'b1, 1'b1);
    check("t1_drained", 32'(sq.size() + aq.size()), 32'd0);

    // restart backward lands on END, then walks down and wraps past START
    increment = 1'b0;
    pulse_restart();
    play_word(EA, 1'b0);
    for (int a = int'(EA) - 1; a >= 0; a--) play_word(AW'(a), 1'b0);

    // forward from END wraps to START; increment flipped mid-word only affects the next word
    increment = 1'b1;
    play_word(EA, 1'b1);
    expect_word(SA, 1'b1);
    tick();
    cycles(20);
    increment = 1'b0;
    tick();
    cycles(20);
    play_word(SA + 1'b1, 1'b0);

    // restart (with a coincident tick) while waiting for data at addr 5
    increment = 1'b1;
    pulse_restart();
    for (int a = 0; a < 5; a++) play_word(AW'(a), 1'b1);
    cfg_lat = 6;
    aq.push_back(AW'(5));
    base    = accept_cnt;
    ov_base = ov_cnt;
    sv_base = sv_cnt;
    tick();
    for (int i = 0; i < 50 && accept_cnt == base; i++) @(negedge clk);
    check("t4_accepted", 32'(accept_cnt), 32'(base + 1));
    @(negedge clk) begin restart = 1'b1; sample_tick = 1'b1; end
    @(negedge clk) begin restart = 1'b0; sample_tick = 1'b0; end
    cycles(20);
    check("t4_no_overrun", 32'(ov_cnt), 32'(ov_base));
    check("t4_no_sample", 32'(sv_cnt), 32'(sv_base));
    cfg_lat = 2;
    play_word(SA, 1'b1);

    // pause in SECOND_WAIT holds the first half; in IDLE it blocks the fetch
    expect_word(SA + 1'b1, 1'b1);
    tick();
    cycles(20);
    pause   = 1'b1;
    sv_base = sv_cnt;
    base    = accept_cnt;
    repeat (5) begin
      tick();
      cycles(15);
    end
    check("t5_no_sample", 32'(sv_cnt), 32'(sv_base));
    check("t5_no_read", 32'(accept_cnt), 32'(base));
    check("t5_sample_held", 32'(sample), 32'h0001);
    pause = 1'b0;
    tick();
    cycles(20);
    check("t5_resume", 32'(sv_cnt), 32'(sv_base + 1));
    pause = 1'b1;
    tick();
    cycles(10);
    check("t5_idle_paused", 32'(accept_cnt), 32'(base));
    pause = 1'b0;

    // tick during a long waitrequest: one overrun, then normal playback
    cfg_wait = 30;
    ov_base  = ov_cnt;
    expect_word(AW'(2), 1'b1);
    tick();
    cycles(10);
    tick();
    cycles(60);
    check("t6_overrun", 32'(ov_cnt), 32'(ov_base + 1));
    tick();
    cycles(20);
    cfg_wait = 2;
    play_word(AW'(3), 1'b1);
    check("t6_no_extra_overrun", 32'(ov_cnt), 32'(ov_base + 1));

    check("final_samples_drained", 32'(sq.size()), 32'd0);
    check("final_reads_drained", 32'(aq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
